// File: rtl/sym_vn_pkg.sv
// Shared widths and address payload for the symmetric VN IB-LUT storage core.
package sym_vn_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned PAGE_W    = 6;
  localparam int unsigned Y0_W      = 3;
  localparam int unsigned Y1_W      = 4;

  // One table-select bit on top of the page address gives the per-bank depth.
  localparam int unsigned TBL_AW    = PAGE_W + 1;
  localparam int unsigned TBL_DEPTH = 2 ** TBL_AW;

  // Folded read address: which bank, and which page inside it.
  typedef struct packed {
    logic              bank;
    logic [PAGE_W-1:0] page;
  } lut_addr_t;

endpackage

// File: rtl/vn_addr_map.sv
// Folds (y0, y1) message pairs of both read ports into {bank, page}.
module vn_addr_map
  import sym_vn_pkg::*;
(
  input  logic [Y0_W-1:0] y0_a_i,
  input  logic [Y1_W-1:0] y1_a_i,
  input  logic [Y0_W-1:0] y0_b_i,
  input  logic [Y1_W-1:0] y1_b_i,
  output lut_addr_t       addr_a_c_o,
  output lut_addr_t       addr_b_c_o
);

  // y1 LSB picks the bank; remaining y1 bits extend y0 into the page.
  always_comb begin
    addr_a_c_o.bank = y1_a_i[0];
    addr_a_c_o.page = {y0_a_i, y1_a_i[Y1_W-1:1]};
    addr_b_c_o.bank = y1_b_i[0];
    addr_b_c_o.page = {y0_b_i, y1_b_i[Y1_W-1:1]};
  end

endmodule

// File: rtl/sym_vn_lut_core.sv
// Two-read / one-write LUT storage for the symmetric 2-input VN IB-LUT.
// Optional macro SYM_VN_IN_REG_EN registers the read-side inputs, making
// read latency 2 cycles instead of 1. Write path is identical either way.
module sym_vn_lut_core
  import sym_vn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [Y0_W-1:0]   y0_in_A,
  input  logic [Y1_W-1:0]   y1_in_A,
  input  logic [Y0_W-1:0]   y0_in_B,
  input  logic [Y1_W-1:0]   y1_in_B,
  input  logic              read_addr_offset,
  output logic [DATA_W-1:0] lut_out_A,
  output logic [DATA_W-1:0] lut_out_B,
  input  logic [DATA_W-1:0] lut_in_bank0,
  input  logic [DATA_W-1:0] lut_in_bank1,
  input  logic [PAGE_W-1:0] page_write_addr,
  input  logic              write_addr_offset,
  input  logic              we
);

  logic [Y0_W-1:0] y0_a;
  logic [Y1_W-1:0] y1_a;
  logic [Y0_W-1:0] y0_b;
  logic [Y1_W-1:0] y1_b;
  logic            rd_off;

`ifdef SYM_VN_IN_REG_EN
  logic [Y0_W-1:0] y0_a_q;
  logic [Y1_W-1:0] y1_a_q;
  logic [Y0_W-1:0] y0_b_q;
  logic [Y1_W-1:0] y1_b_q;
  logic            rd_off_q;

  // Input staging registers ahead of the address fold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y0_a_q   <= '0;
      y1_a_q   <= '0;
      y0_b_q   <= '0;
      y1_b_q   <= '0;
      rd_off_q <= 1'b0;
    end else begin
      y0_a_q   <= y0_in_A;
      y1_a_q   <= y1_in_A;
      y0_b_q   <= y0_in_B;
      y1_b_q   <= y1_in_B;
      rd_off_q <= read_addr_offset;
    end
  end

  assign y0_a   = y0_a_q;
  assign y1_a   = y1_a_q;
  assign y0_b   = y0_b_q;
  assign y1_b   = y1_b_q;
  assign rd_off = rd_off_q;
`else
  assign y0_a   = y0_in_A;
  assign y1_a   = y1_in_A;
  assign y0_b   = y0_in_B;
  assign y1_b   = y1_in_B;
  assign rd_off = read_addr_offset;
`endif

  lut_addr_t addr_a;
  lut_addr_t addr_b;

  vn_addr_map u_addr_map (
    .y0_a_i     (y0_a),
    .y1_a_i     (y1_a),
    .y0_b_i     (y0_b),
    .y1_b_i     (y1_b),
    .addr_a_c_o (addr_a),
    .addr_b_c_o (addr_b)
  );

  logic [DATA_W-1:0] bank0_mem [TBL_DEPTH];
  logic [DATA_W-1:0] bank1_mem [TBL_DEPTH];

  logic [TBL_AW-1:0] rd_idx_a;
  logic [TBL_AW-1:0] rd_idx_b;
  logic [TBL_AW-1:0] wr_idx;

  assign rd_idx_a = {rd_off, addr_a.page};
  assign rd_idx_b = {rd_off, addr_b.page};
  assign wr_idx   = {write_addr_offset, page_write_addr};

  // Both banks are written as a pair; reset blocks writes but never clears storage.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      bank0_mem[wr_idx] <= lut_in_bank0;
      bank1_mem[wr_idx] <= lut_in_bank1;
    end
  end

  logic [DATA_W-1:0] lut_a_d;
  logic [DATA_W-1:0] lut_b_d;
  logic [DATA_W-1:0] lut_a_q;
  logic [DATA_W-1:0] lut_b_q;

  // Independent asynchronous reads per port, bank chosen by the folded address.
  always_comb begin
    lut_a_d = addr_a.bank ? bank1_mem[rd_idx_a] : bank0_mem[rd_idx_a];
    lut_b_d = addr_b.bank ? bank1_mem[rd_idx_b] : bank0_mem[rd_idx_b];
  end

  // Output registers; sampling pre-write array contents gives read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_a_q <= '0;
      lut_b_q <= '0;
    end else begin
      lut_a_q <= lut_a_d;
      lut_b_q <= lut_b_d;
    end
  end

  assign lut_out_A = lut_a_q;
  assign lut_out_B = lut_b_q;

endmodule

// File: tb/tb_sym_vn_lut_core.sv
// Directed, table-driven bench for sym_vn_lut_core.
module tb_sym_vn_lut_core;

`ifdef SYM_VN_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] y0_in_A = '0;
  logic [3:0] y1_in_A = '0;
  logic [2:0] y0_in_B = '0;
  logic [3:0] y1_in_B = '0;
  logic       read_addr_offset = 1'b0;
  logic [3:0] lut_out_A;
  logic [3:0] lut_out_B;
  logic [3:0] lut_in_bank0 = '0;
  logic [3:0] lut_in_bank1 = '0;
  logic [5:0] page_write_addr = '0;
  logic       write_addr_offset = 1'b0;
  logic       we = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  sym_vn_lut_core dut (
    .clk               (clk),
    .rst               (rst),
    .y0_in_A           (y0_in_A),
    .y1_in_A           (y1_in_A),
    .y0_in_B           (y0_in_B),
    .y1_in_B           (y1_in_B),
    .read_addr_offset  (read_addr_offset),
    .lut_out_A         (lut_out_A),
    .lut_out_B         (lut_out_B),
    .lut_in_bank0      (lut_in_bank0),
    .lut_in_bank1      (lut_in_bank1),
    .page_write_addr   (page_write_addr),
    .write_addr_offset (write_addr_offset),
    .we                (we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] y0a;
    logic [3:0] y1a;
    logic [2:0] y0b;
    logic [3:0] y1b;
    logic       off;
    logic [3:0] ea;
    logic [3:0] eb;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a paired write; called just after a falling edge.
  task automatic wr(input logic [5:0] page, input logic off, input logic [3:0] d0, input logic [3:0] d1);
    page_write_addr   = page;
    write_addr_offset = off;
    lut_in_bank0      = d0;
    lut_in_bank1      = d1;
    we                = 1'b1;
    @(negedge clk);
    we                = 1'b0;
  endtask

  task automatic set_rd(input logic [2:0] y0a, input logic [3:0] y1a,
                        input logic [2:0] y0b, input logic [3:0] y1b, input logic off);
    y0_in_A = y0a; y1_in_A = y1a;
    y0_in_B = y0b; y1_in_B = y1b;
    read_addr_offset = off;
  endtask

  // Reference location number {offset, bank, page} from the folding rule.
  function automatic logic [7:0] maddr(input logic off, input logic [2:0] y0, input logic [3:0] y1);
    logic [7:0] a;
    a = {off, y1[0], y0, y1[3:1]};
    return a;
  endfunction

  function automatic logic [3:0] hword(input logic [7:0] a);
    return 4'(a ^ (a >> 4) ^ (a >> 6) ^ (a >> 7));
  endfunction

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_A", lut_out_A, 4'h0);
    chk("reset_out_B", lut_out_B, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // Seed locations used by the vector table.
    wr(6'd43, 1'b0, 4'hA, 4'h5);
    wr(6'd0,  1'b0, 4'h3, 4'h4);
    wr(6'd0,  1'b1, 4'hC, 4'hD);
    wr(6'd63, 1'b0, 4'h2, 4'hE);

    vecs[0] = '{3'd5, 4'b0110, 3'd5, 4'b0111, 1'b0, 4'hA, 4'h5};
    vecs[1] = '{3'd0, 4'b0000, 3'd0, 4'b0001, 1'b0, 4'h3, 4'h4};
    vecs[2] = '{3'd0, 4'b0000, 3'd0, 4'b0001, 1'b1, 4'hC, 4'hD};
    vecs[3] = '{3'd7, 4'hF,    3'd7, 4'hF,    1'b0, 4'hE, 4'hE};
    vecs[4] = '{3'd7, 4'hE,    3'd5, 4'b0110, 1'b0, 4'h2, 4'hA};

    for (int i = 0; i < 5; i++) begin
      set_rd(vecs[i].y0a, vecs[i].y1a, vecs[i].y0b, vecs[i].y1b, vecs[i].off);
      repeat (LAT) @(negedge clk);
      chk($sformatf("vec%0d_A", i), lut_out_A, vecs[i].ea);
      chk($sformatf("vec%0d_B", i), lut_out_B, vecs[i].eb);
    end

    // Asynchronous reset between clocks, with a write attempted while held.
    set_rd(3'd5, 4'b0110, 3'd5, 4'b0111, 1'b0);
    repeat (LAT) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_A", lut_out_A, 4'h0);
    chk("rst_async_B", lut_out_B, 4'h0);
    page_write_addr = 6'd43; write_addr_offset = 1'b0;
    lut_in_bank0 = 4'h0; lut_in_bank1 = 4'h0; we = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hold_A", lut_out_A, 4'h0);
    chk("rst_hold_B", lut_out_B, 4'h0);
    rst = 1'b0; we = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("post_rst_A", lut_out_A, 4'hA);
    chk("post_rst_B", lut_out_B, 4'h5);

    // Read-during-write on page 10, table 1: old word first, new word next.
    wr(6'd10, 1'b1, 4'h1, 4'h6);
    set_rd(3'd1, 4'b0100, 3'd1, 4'b0101, 1'b1);
    repeat (LAT - 1) @(negedge clk);
    wr(6'd10, 1'b1, 4'h9, 4'h7);
    chk("rdw_old_A", lut_out_A, 4'h1);
    chk("rdw_old_B", lut_out_B, 4'h6);
    @(negedge clk);
    chk("rdw_new_A", lut_out_A, 4'h9);
    chk("rdw_new_B", lut_out_B, 4'h7);

    // Fill every location with an address-derived word, then read all combinations.
    for (int o = 0; o < 2; o++) begin
      for (int p = 0; p < 64; p++) begin
        logic [7:0] a0;
        logic [7:0] a1;
        a0 = {1'(o), 1'b0, 6'(p)};
        a1 = {1'(o), 1'b1, 6'(p)};
        wr(6'(p), 1'(o), hword(a0), hword(a1));
      end
    end
    for (int o = 0; o < 2; o++) begin
      for (int y0 = 0; y0 < 8; y0++) begin
        for (int y1 = 0; y1 < 16; y1++) begin
          logic [2:0] ya0;
          logic [3:0] ya1;
          logic [2:0] yb0;
          logic [3:0] yb1;
          ya0 = 3'(y0);
          ya1 = 4'(y1);
          yb0 = ~ya0;
          yb1 = ~ya1;
          set_rd(ya0, ya1, yb0, yb1, 1'(o));
          repeat (LAT) @(negedge clk);
          chk($sformatf("sweep_A o%0d y0=%0d y1=%0d", o, ya0, ya1), lut_out_A, hword(maddr(1'(o), ya0, ya1)));
          chk($sformatf("sweep_B o%0d y0=%0d y1=%0d", o, yb0, yb1), lut_out_B, hword(maddr(1'(o), yb0, yb1)));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
